// File: rtl/ahb_seven_seg_scanner.sv
// Multiplexed common-anode 7-segment scanner for a 32-bit port value, double-buffered per frame.
// Optional macro LEADING_ZERO_BLANK_EN blanks segments a-g of leading-zero digits.
module ahb_seven_seg_scanner #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] iValue,
  input  logic [7:0]  iDp,
  input  logic        iLoad,
  output logic [7:0]  nSegments,
  output logic [7:0]  nDigit,
  output logic        oFrameDone
);

  localparam int unsigned PW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BlankEnd  = PW'(BLANK_CYCLES);
  localparam logic [2:0]    IdxLast   = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]    DigMask   = 8'((1 << NUM_DIGITS) - 1);

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [31:0]   r_pend_val;
  logic [7:0]    r_pend_dp;
  logic          r_pend_vld;
  logic [31:0]   r_disp_val;
  logic [7:0]    r_disp_dp;

  logic       w_slot_end;
  logic       w_frame_end;
  logic [3:0] w_nib;
  logic       w_lz_blank;
  logic [6:0] w_seg_on;

  assign w_slot_end  = (r_presc == PrescLast);
  assign w_frame_end = w_slot_end && (r_idx == IdxLast);
  assign w_nib       = r_disp_val[{r_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0] w_msnz;

  // Highest nonzero nibble of the display buffer; stays 0 for an all-zero value.
  always_comb begin
    w_msnz = 3'd0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (r_disp_val[4*k +: 4] != 4'h0) w_msnz = 3'(k);
    end
  end

  assign w_lz_blank = (r_idx > w_msnz);
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_seg_on = w_lz_blank ? 7'h00 : seg7(w_nib);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_presc    <= '0;
      r_idx      <= 3'd0;
      r_pend_val <= 32'h0;
      r_pend_dp  <= 8'h0;
      r_pend_vld <= 1'b0;
      r_disp_val <= 32'h0;
      r_disp_dp  <= 8'h0;
      nSegments  <= 8'hFF;
      nDigit     <= 8'hFF;
      oFrameDone <= 1'b0;
    end else begin
      r_presc <= w_slot_end ? '0 : r_presc + PW'(1);
      if (w_slot_end) r_idx <= (r_idx == IdxLast) ? 3'd0 : r_idx + 3'd1;
      oFrameDone <= w_frame_end;

      if (w_frame_end && r_pend_vld) begin
        r_disp_val <= r_pend_val;
        r_disp_dp  <= r_pend_dp;
        r_pend_vld <= 1'b0;
      end
      // A load on the frame-end cycle must win over the clear above and stay pending.
      if (iLoad) begin
        r_pend_val <= iValue;
        r_pend_dp  <= iDp;
        r_pend_vld <= 1'b1;
      end

      if (r_presc < BlankEnd) begin
        nSegments <= 8'hFF;
        nDigit    <= 8'hFF;
      end else begin
        nSegments <= ~{r_disp_dp[r_idx], w_seg_on};
        nDigit    <= ~(8'h01 << r_idx) | ~DigMask;
      end
    end
  end

endmodule
